// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width used by both the kit top and its bench.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Kit 1-bit full-adder cell; the serial controller feeds it one bit pair per clock.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic ca
);

    assign sum = a ^ b ^ cin;
    assign ca  = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures operands on start, streams them LSB
// first through one Full_Adder cell and presents {cout, sum} with a done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic [CW-1:0]    cnt;
    logic             c_reg;
    logic             s;
    logic             co;
    logic             last;

    Full_Adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (c_reg),
        .sum (s),
        .ca  (co)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Concatenate-then-shift keeps the sum insertion legal even when WIDTH = 1.
    assign sum_next = WIDTH'({s, sum_sh} >> 1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry feedback and bit counter; the visible
    // result registers only move on the final bit of an operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        c_reg  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    c_reg  <= co;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum  <= sum_next;
                        cout <= co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
